// File: rtl/cprs_row_acc.sv
// Two-stage accumulator for rows of approximate 4:2 compressor outputs.
// Sums row values and error flags per frame, with saturation and a result handshake.
module cprs_row_acc #(
  parameter int W     = 8,
  parameter int ACC_W = 20,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_sum,
  input  logic [W-1:0]     in_carry,
  input  logic [W-1:0]     in_err,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_err_cnt,
  output logic             out_ovf
);

  localparam int PC_W = $clog2(W + 1);

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_e;

  state_e           state_q;
  logic             s1_valid_q;
  logic             s1_last_q;
  logic [W+1:0]     s1_val_q;
  logic [PC_W-1:0]  s1_pc_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] err_q;
  logic             ovf_q;

  logic             accept;
  logic [W+1:0]     row_d;
  logic [PC_W-1:0]  pc_d;
  logic [ACC_W:0]   acc_sum;
  logic [CNT_W:0]   err_sum;
  logic             acc_sat;
  logic             err_sat;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] err_d;

  // A held last row blocks intake until the frame result is taken.
  assign in_ready = rst_n && (state_q == ACC)
                    && !(s1_valid_q && s1_last_q);
  assign accept   = in_valid && in_ready;

  assign row_d = {2'b00, in_sum} + {1'b0, in_carry, 1'b0};

  // Count the error flags of the incoming row.
  always_comb begin
    pc_d = '0;
    for (int i = 0; i < W; i++) begin
      pc_d = pc_d + PC_W'(in_err[i]);
    end
  end

  // Saturating adds of the stage-1 row into the running totals.
  always_comb begin
    acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(s1_val_q);
    err_sum = {1'b0, err_q} + (CNT_W + 1)'(s1_pc_q);
    acc_sat = acc_sum[ACC_W];
    err_sat = err_sum[CNT_W];
    acc_d   = acc_sat ? '1 : acc_sum[ACC_W-1:0];
    err_d   = err_sat ? '1 : err_sum[CNT_W-1:0];
  end

  // Stage 1: capture the reduced row on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_val_q   <= '0;
      s1_pc_q    <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_last_q <= in_last;
        s1_val_q  <= row_d;
        s1_pc_q   <= pc_d;
      end
    end
  end

  // Stage 2 and frame FSM: accumulate, then hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      err_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (s1_valid_q) begin
            acc_q <= acc_d;
            err_q <= err_d;
            ovf_q <= ovf_q | acc_sat | err_sat;
            if (s1_last_q) state_q <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            acc_q   <= '0;
            err_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= ACC;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign out_valid   = (state_q == OUT);
  assign out_acc     = acc_q;
  assign out_err_cnt = err_q;
  assign out_ovf     = ovf_q;

endmodule

// File: tb/tb_cprs_row_acc.sv
// Bench for cprs_row_acc: directed frames plus random traffic
// against a frame-level reference model, on two width configurations.
module tb_cprs_row_acc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_sum;
  logic [7:0] in_carry;
  logic [7:0] in_err;
  logic       in_last;
  logic       out_ready;

  logic        rdy_a, vld_a, ovf_a;
  logic [19:0] acc_a;
  logic [7:0]  cnt_a;
  logic        rdy_b, vld_b, ovf_b;
  logic [9:0]  acc_b;
  logic [3:0]  cnt_b;

  int checks = 0;
  int failures = 0;

  // model state
  bit     busy;
  bit     fin_stage;
  bit     exp_valid;
  longint tot_acc, tot_err;
  longint f_acc, f_err;

  always #5 clk = ~clk;

  cprs_row_acc u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy_a),
    .in_sum(in_sum), .in_carry(in_carry),
    .in_err(in_err), .in_last(in_last),
    .out_valid(vld_a), .out_ready(out_ready),
    .out_acc(acc_a), .out_err_cnt(cnt_a),
    .out_ovf(ovf_a)
  );

  cprs_row_acc #(.W(8), .ACC_W(10), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy_b),
    .in_sum(in_sum), .in_carry(in_carry),
    .in_err(in_err), .in_last(in_last),
    .out_valid(vld_b), .out_ready(out_ready),
    .out_acc(acc_b), .out_err_cnt(cnt_b),
    .out_ovf(ovf_b)
  );

  task automatic chk(input string tag,
                     input longint got,
                     input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint v,
                                 input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    busy = 0; fin_stage = 0; exp_valid = 0;
    tot_acc = 0; tot_err = 0; f_acc = 0; f_err = 0;
  endtask

  task automatic check_outs();
    bit er;
    er = (rst_n == 1'b1) && !busy;
    chk("rdy_a", longint'(rdy_a), longint'(er));
    chk("rdy_b", longint'(rdy_b), longint'(er));
    chk("vld_a", longint'(vld_a), longint'(exp_valid));
    chk("vld_b", longint'(vld_b), longint'(exp_valid));
    if (exp_valid) begin
      chk("acc_a", longint'(acc_a), sat(f_acc, 20'hFFFFF));
      chk("cnt_a", longint'(cnt_a), sat(f_err, 255));
      chk("ovf_a", longint'(ovf_a),
          longint'(f_acc > 20'hFFFFF || f_err > 255));
      chk("acc_b", longint'(acc_b), sat(f_acc, 1023));
      chk("cnt_b", longint'(cnt_b), sat(f_err, 15));
      chk("ovf_b", longint'(ovf_b),
          longint'(f_acc > 1023 || f_err > 15));
    end
  endtask

  task automatic model_step();
    bit acc, hs;
    hs  = exp_valid && out_ready;
    acc = in_valid && !busy;
    if (hs) begin
      exp_valid = 0;
      busy = 0;
    end
    if (fin_stage) begin
      exp_valid = 1;
      fin_stage = 0;
    end
    if (acc) begin
      tot_acc += longint'(in_sum) + 2 * longint'(in_carry);
      tot_err += longint'($countones(in_err));
      if (in_last) begin
        busy = 1; fin_stage = 1;
        f_acc = tot_acc; f_err = tot_err;
        tot_acc = 0; tot_err = 0;
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] s,
                     input logic [7:0] c, input logic [7:0] e,
                     input logic l, input logic ordy);
    @(negedge clk);
    check_outs();
    in_valid = v; in_sum = s; in_carry = c;
    in_err = e; in_last = l; out_ready = ordy;
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 8'($urandom), 8'($urandom), 8'($urandom),
          1'($urandom), ordy);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 8 && !exp_valid; i++) idle(1, 1'b0);
    @(negedge clk);
    chk("wait_valid", longint'(vld_a), 1);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      in_valid = 1'($urandom); in_sum = 8'($urandom);
      in_carry = 8'($urandom); in_err = 8'($urandom);
      in_last = 1'($urandom); out_ready = 1'($urandom);
      #1;
      chk("rst_rdy", longint'(rdy_a), 0);
      chk("rst_vld", longint'(vld_a), 0);
      chk("rst_acc", longint'(acc_a), 0);
      chk("rst_cnt", longint'(cnt_a), 0);
      chk("rst_ovf", longint'(ovf_a), 0);
      chk("rst_accb", longint'(acc_b), 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_sum = 0; in_carry = 0;
    in_err = 0; in_last = 0; out_ready = 0;
    model_reset();

    // reset
    do_reset(3);
    idle(3, 1'b1);

    // single-row frame
    cyc(1'b1, 8'h0F, 8'h01, 8'h03, 1'b1, 1'b1);
    wait_valid();
    chk("s2_acc", longint'(acc_a), 17);
    chk("s2_cnt", longint'(cnt_a), 2);
    chk("s2_ovf", longint'(ovf_a), 0);
    idle(3, 1'b1);

    // three rows with gaps
    cyc(1'b1, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b1, 8'h01, 8'h00, 8'hFF, 1'b0, 1'b0);
    idle(1, 1'b0);
    cyc(1'b1, 8'h00, 8'h80, 8'h01, 1'b1, 1'b0);
    wait_valid();
    chk("s3_acc", longint'(acc_a), 1022);
    chk("s3_cnt", longint'(cnt_a), 9);

    // backpressure with in_valid held
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 8'($urandom), 8'($urandom), 8'($urandom),
          1'b0, 1'b0);
    cyc(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    idle(1, 1'b1);
    cyc(1'b1, 8'h02, 8'h00, 8'h00, 1'b1, 1'b0);
    wait_valid();
    chk("s4_acc", longint'(acc_a), 2);
    idle(1, 1'b1);

    // saturation on the narrow instance
    cyc(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    wait_valid();
    chk("s5_acc", longint'(acc_b), 1023);
    chk("s5_cnt", longint'(cnt_b), 15);
    chk("s5_ovf", longint'(ovf_b), 1);
    chk("s5_acca", longint'(acc_a), 1530);
    idle(1, 1'b1);
    cyc(1'b1, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
    wait_valid();
    chk("s5_ovf2", longint'(ovf_b), 0);
    idle(1, 1'b1);

    // reset mid-frame
    cyc(1'b1, 8'h33, 8'h11, 8'h0F, 1'b0, 1'b0);
    cyc(1'b1, 8'h44, 8'h22, 8'hF0, 1'b0, 1'b0);
    do_reset(1);
    cyc(1'b1, 8'h02, 8'h00, 8'h00, 1'b1, 1'b0);
    wait_valid();
    chk("s6_acc", longint'(acc_a), 2);
    chk("s6_cnt", longint'(cnt_a), 0);
    idle(1, 1'b1);

    // random traffic
    for (int i = 0; i < 500; i++)
      cyc(1'($urandom_range(0, 9) < 7), 8'($urandom),
          8'($urandom), 8'($urandom),
          1'($urandom_range(0, 9) < 2),
          1'($urandom_range(0, 9) < 6));
    idle(6, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/cprs_row_acc.md
CPRS_ROW_ACC -- requirements
Module: cprs_row_acc

Interface
REQ-001 Parameter W, default 8: row width, equal to the number of approximate 4:2 compressors feeding this block.
REQ-002 Parameter ACC_W, default 20: accumulator width; legal range W+2 to 32.
REQ-003 Parameter CNT_W, default 8: error-counter width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  the upstream row is valid.
REQ-008 in_ready  output  1  the block accepts a row this cycle.
REQ-009 in_sum  input  W  summ bits of the compressor row, bit i has weight 2^i.
REQ-010 in_carry  input  W  carry bits of the compressor row, bit i has weight 2^(i+1).
REQ-011 in_err  input  W  per-compressor approximation error flags.
REQ-012 in_last  input  1  marks the final row of a frame.
REQ-013 out_valid  output  1  the frame result is valid.
REQ-014 out_ready  input  1  the downstream consumer accepts the result.
REQ-015 out_acc  output  ACC_W  frame sum.
REQ-016 out_err_cnt  output  CNT_W  total number of err flags in the frame.
REQ-017 out_ovf  output  1  out_acc or out_err_cnt saturated during the frame.

Function
REQ-018 A row SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; no other edge accepts a row.
REQ-019 Stage 1 SHALL register row_val = in_sum + (in_carry << 1), computed at W+2 bits with no loss, plus popcount(in_err), the in_last bit, and a s1_valid flag.
REQ-020 Stage 2 SHALL add row_val into acc and the popcount into err_cnt on the edge after acceptance.
REQ-021 Both additions SHALL saturate: acc at 2^ACC_W-1 and err_cnt at 2^CNT_W-1; any saturation sets the sticky flag ovf for the current frame.
REQ-022 The FSM SHALL have two states, ACC (accumulating) and OUT (result pending).
REQ-023 ACC->OUT SHALL occur on the edge where stage 2 consumes a row with last=1; that edge also performs the accumulation for that row.
REQ-024 OUT->ACC SHALL occur on an edge where out_valid=1 and out_ready=1; that edge clears acc, err_cnt and ovf to 0.
REQ-025 in_ready SHALL equal 1 only when state=ACC and no last row is held in stage 1 or stage 2.
REQ-026 Consequence of REQ-025: in_ready drops the cycle after a last row is accepted and rises the cycle after the output handshake.
REQ-027 out_valid SHALL equal 1 exactly when state=OUT; out_acc, out_err_cnt and out_ovf SHALL then present acc, err_cnt and ovf, held stable until the handshake.
REQ-028 Latency: a last row accepted at edge E0 SHALL make out_valid=1 in the cycle following edge E0+1.
REQ-029 Gaps in in_valid SHALL be allowed mid-frame; a cycle without a valid row SHALL leave acc and err_cnt unchanged.
REQ-030 A frame of a single row, with in_last=1 on its only row, SHALL be legal.
REQ-031 out_ready SHALL be ignored while out_valid=0.
REQ-032 While out_valid=0, out_acc, out_err_cnt and out_ovf SHALL still reflect the running values but carry no meaning.

Reset
REQ-033 On rst_n=0, asynchronously: state=ACC; acc, err_cnt, ovf, s1_valid and the pipeline last flags=0; out_valid=0; out_acc=0; out_err_cnt=0; out_ovf=0.
REQ-034 in_ready SHALL be 0 while rst_n=0 and 1 from the first cycle after deassertion.
REQ-035 Reset asserted mid-frame or in OUT SHALL discard all partial results; no output handshake occurs for that frame.

Verification
REQ-036 Scenario 1, reset:
- Stimulus: assert rst_n=0 with random inputs, then release.
- Required: all outputs 0 during reset; in_ready=1 in the next cycle after release; out_valid stays 0.
REQ-037 Scenario 2, single-row frame:
- Stimulus: sum=0x0F, carry=0x01, err=0x03, last=1, out_ready=1.
- Required: out_valid=1 two cycles after acceptance, with out_acc=17, out_err_cnt=2, out_ovf=0; in_ready returns to 1 after the handshake.
REQ-038 Scenario 3, three-row frame with idle gaps:
- Stimulus: rows (0xFF,0xFF,0x00), (0x01,0x00,0xFF), (0x00,0x80,0x01,last).
- Required: out_acc=765+1+256=1022; out_err_cnt=9.
REQ-039 Scenario 4, backpressure:
- Stimulus: out_ready=0 for 5 cycles while out_valid=1, with in_valid held at 1.
- Required: outputs stable; in_ready=0 and no row accepted; after out_ready=1, exactly one handshake, then the next frame starts from acc=0.
REQ-040 Scenario 5, saturation:
- Stimulus: ACC_W=10, CNT_W=4; two rows of (0xFF,0xFF,0xFF), then last.
- Required: out_acc=1023, out_err_cnt=15, out_ovf=1; the next frame has out_ovf=0.
REQ-041 Scenario 6, reset mid-frame:
- Stimulus: two rows of a frame accepted, then rst_n pulsed low, then a new single-row frame (0x02,0x00,0x00,last).
- Required: out_acc=2, out_err_cnt=0.
